// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
//   state_e     : responder FSM states
//   WORD_W/BE_W : data word and byte-enable widths
//   err codes   : per-cause error flags; rsp_err is the OR of all set flags
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE     = 2'b00;
  localparam err_code_t ERR_RANGE    = 2'b01;
  localparam err_code_t ERR_MISALIGN = 2'b10;

  // True when every address bit above the word index is zero.
  function automatic logic addr_in_range(input logic [WORD_W-1:0] addr,
                                         input int unsigned       addr_w);
    return (addr >> (addr_w + 2)) == '0;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the data-memory responder: 2**ADDR_W x 32-bit words.
//   clk_i, rst_ni : clock; async active-low reset (read register only, storage is not reset)
//   commit_i      : access strobe, asserted on the edge that completes a transaction
//   wr_en_i       : with commit_i, write the enabled bytes of wdata_i to addr_i
//   rd_en_i       : with commit_i, register the word at addr_i onto rdata_o
//   addr_i        : word index
//   wdata_i/be_i  : store data and byte-lane enables (bit i = bits [8i+7:8i])
//   rdata_o       : registered read data; cleared to 0 by any commit that is not a read
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              commit_i,
  input  logic              wr_en_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [BE_W-1:0]   be_i,
  output logic [WORD_W-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [WORD_W-1:0] mem_q [Depth];
  logic [WORD_W-1:0] rdata_d, rdata_q;

  always_ff @(posedge clk_i) begin
    if (commit_i && wr_en_i) begin
      for (int i = 0; i < int'(BE_W); i++) begin
        if (be_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  // Stores and rejected accesses return zero, so the register is cleared rather than held.
  always_comb begin
    rdata_d = rdata_q;
    if (commit_i) begin
      rdata_d = rd_en_i ? mem_q[addr_i] : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the pipeline data-memory port with programmable wait states.
// One request is accepted per req handshake; the response appears WAIT_CYCLES+1 cycles
// after the accept edge and is held until the rsp handshake.
//   CLK, RST_n             : clock; asynchronous active-low reset
//   req_valid/req_ready    : request handshake (ready only while idle)
//   req_we                 : 1 = store, 0 = load
//   req_addr               : byte address; word index is req_addr[ADDR_W+1:2]
//   req_wdata/req_be       : store data and byte-lane enables
//   rsp_valid/rsp_ready    : response handshake
//   rsp_rdata              : load data; 0 for stores and errors
//   rsp_err                : out-of-range (or misaligned, when checked) access
// Build option: define MISALIGN_CHECK_EN to flag req_addr[1:0] != 0 as an error; otherwise
// the low address bits are ignored and the aligned word is used.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  // The counter is loaded with WAIT_CYCLES+1 so that the RESP-entry edge, which is also the
  // commit edge, lands exactly WAIT_CYCLES+1 edges after the accept edge.
  localparam logic [8:0] CntLoad = 9'(WAIT_CYCLES + 1);

  state_e            state_d, state_q;
  logic [8:0]        cnt_d, cnt_q;
  logic              we_d, we_q;
  logic [ADDR_W-1:0] idx_d, idx_q;
  logic [WORD_W-1:0] wdata_d, wdata_q;
  logic [BE_W-1:0]   be_d, be_q;
  err_code_t         err_code_d, err_code_q;
  logic              rsp_valid_d, rsp_valid_q;
  logic              rsp_err_d, rsp_err_q;
  logic              req_ready_d, req_ready_q;

  logic              commit;
  logic              misalign;
  err_code_t         req_err;
  logic              access_ok;

`ifdef MISALIGN_CHECK_EN
  assign misalign = |req_addr[1:0];
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];
  assign misalign        = 1'b0;
`endif

  always_comb begin
    req_err = ERR_NONE;
    if (!addr_in_range(req_addr, ADDR_W)) begin
      req_err = req_err | ERR_RANGE;
    end
    if (misalign) begin
      req_err = req_err | ERR_MISALIGN;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    err_code_d  = err_code_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    commit      = 1'b0;

    case (state_q)
      StIdle: begin
        if (req_valid && req_ready_q) begin
          we_d       = req_we;
          idx_d      = req_addr[ADDR_W+1:2];
          wdata_d    = req_wdata;
          be_d       = req_be;
          err_code_d = req_err;
          cnt_d      = CntLoad;
          state_d    = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 9'd1;
        if (cnt_q == 9'd1) begin
          commit      = 1'b1;
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_err_d   = (err_code_q != ERR_NONE);
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Registered so ready stays low while reset is asserted and during the rsp handshake.
    req_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      err_code_q  <= ERR_NONE;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      err_code_q  <= err_code_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign access_ok = (err_code_q == ERR_NONE);

  dmem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk_i    (CLK),
    .rst_ni   (RST_n),
    .commit_i (commit),
    .wr_en_i  (we_q && access_ok),
    .rd_en_i  (!we_q && access_ok),
    .addr_i   (idx_q),
    .wdata_i  (wdata_q),
    .be_i     (be_q),
    .rdata_o  (rsp_rdata)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized traffic
// compared against a word-array reference model.
module tb_dmem_responder;

  localparam int unsigned AddrW      = 6;
  localparam int unsigned WaitCycles = 2;
  localparam int unsigned Words      = 2 ** AddrW;
`ifdef MISALIGN_CHECK_EN
  localparam bit MisEn = 1'b1;
`else
  localparam bit MisEn = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int failures = 0;

  logic [31:0] model [Words];

  always #5 CLK = ~CLK;

  dmem_responder #(
    .ADDR_W      (AddrW),
    .WAIT_CYCLES (WaitCycles)
  ) dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: applies one access to the model and returns the expected response.
  task automatic ref_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, output logic [31:0] exp_rdata,
                            output logic exp_err);
    logic [31:0] hi;
    int          idx;
    hi      = addr >> (AddrW + 2);
    exp_err = (hi != 0) || (MisEn && (addr % 4 != 0));
    idx     = int'((addr / 4) % Words);
    exp_rdata = '0;
    if (!exp_err) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
        end
      end else begin
        exp_rdata = model[idx];
      end
    end
  endtask

  // Called on a negedge; returns on the negedge after the accept edge.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be);
    int n;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
    end
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
  endtask

  // Counts negedges after the accept edge until rsp_valid is seen.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 400) begin
      @(negedge CLK);
      lat++;
    end
  endtask

  task automatic finish_rsp(output logic cleared);
    rsp_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    rsp_ready = 1'b0;
    cleared = (rsp_valid === 1'b0);
  endtask

  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata, output logic err,
                        output int lat, output logic cleared);
    issue(we, addr, wdata, be);
    wait_rsp(lat);
    rdata = rsp_rdata;
    err   = rsp_err;
    finish_rsp(cleared);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid);
    end
    checks++;
    if (req_ready !== 1'b0) begin
      failures++; $display("FAIL reset_req_ready: got %b required 0", req_ready);
    end
    checks++;
    if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_rsp_data: rdata=%h err=%b required 0/0", rsp_rdata, rsp_err);
    end
    RST_n = 1'b1;
    @(negedge CLK);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL ready_after_reset: got %b required 1", req_ready);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd, er;
    logic        e, ee, cl;
    int          lat;
    ref_access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, er, ee);
    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat, cl);
    checks++;
    if (lat != int'(WaitCycles) + 1 || e !== 1'b0 || rd !== 32'h0) begin
      failures++;
      $display("FAIL store_0x10: lat=%0d err=%b rdata=%h required lat=%0d err=0 rdata=0",
               lat, e, rd, WaitCycles + 1);
    end
    checks++;
    if (cl !== 1'b1) begin
      failures++; $display("FAIL store_rsp_clear: rsp_valid still high after handshake");
    end
    ref_access(1'b0, 32'h10, 32'h0, 4'h0, er, ee);
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat, cl);
    checks++;
    if (lat != int'(WaitCycles) + 1 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL load_0x10: lat=%0d err=%b rdata=%h required lat=%0d err=0 rdata=deadbeef",
               lat, e, rd, WaitCycles + 1);
    end
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd, er;
    logic        e, ee, cl;
    int          lat;
    ref_access(1'b1, 32'h10, 32'h000000AA, 4'b0001, er, ee);
    do_txn(1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, e, lat, cl);
    ref_access(1'b0, 32'h10, 32'h0, 4'h0, er, ee);
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat, cl);
    checks++;
    if (rd !== 32'hDEADBEAA || e !== 1'b0) begin
      failures++;
      $display("FAIL byte_lane0: rdata=%h err=%b required deadbeaa/0", rd, e);
    end
    ref_access(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, er, ee);
    do_txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, e, lat, cl);
    checks++;
    if (e !== 1'b0 || lat != int'(WaitCycles) + 1) begin
      failures++; $display("FAIL be_zero_rsp: err=%b lat=%0d required err=0", e, lat);
    end
    ref_access(1'b0, 32'h10, 32'h0, 4'h0, er, ee);
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat, cl);
    checks++;
    if (rd !== er) begin
      failures++; $display("FAIL be_zero_nowrite: rdata=%h required %h", rd, er);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd, er;
    logic        e, ee, cl;
    int          lat;
    ref_access(1'b1, 32'h0, 32'h11223344, 4'hF, er, ee);
    do_txn(1'b1, 32'h0, 32'h11223344, 4'hF, rd, e, lat, cl);
    do_txn(1'b0, 32'h400, 32'h0, 4'h0, rd, e, lat, cl);
    checks++;
    if (e !== 1'b1 || rd !== 32'h0 || lat != int'(WaitCycles) + 1) begin
      failures++;
      $display("FAIL oor_load: err=%b rdata=%h lat=%0d required 1/0/%0d", e, rd, lat,
               WaitCycles + 1);
    end
    do_txn(1'b1, 32'h400, 32'h55667788, 4'hF, rd, e, lat, cl);
    checks++;
    if (e !== 1'b1) begin
      failures++; $display("FAIL oor_store_err: err=%b required 1", e);
    end
    ref_access(1'b0, 32'h0, 32'h0, 4'h0, er, ee);
    do_txn(1'b0, 32'h0, 32'h0, 4'h0, rd, e, lat, cl);
    checks++;
    if (rd !== 32'h11223344 || e !== 1'b0) begin
      failures++; $display("FAIL oor_no_write: rdata=%h err=%b required 11223344/0", rd, e);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] er;
    logic        ee, cl;
    int          lat;
    ref_access(1'b0, 32'h10, 32'h0, 4'h0, er, ee);
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    wait_rsp(lat);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== er || rsp_err !== ee || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d: valid=%b rdata=%h err=%b ready=%b required 1/%h/%b/0",
                 i, rsp_valid, rsp_rdata, rsp_err, req_ready, er, ee);
      end
      @(negedge CLK);
    end
    finish_rsp(cl);
    checks++;
    if (cl !== 1'b1 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_release: valid=%b ready=%b required 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, er;
    logic        e, ee, cl;
    int          lat;
    ref_access(1'b1, 32'h20, 32'h12345678, 4'hF, er, ee);
    do_txn(1'b1, 32'h20, 32'h12345678, 4'hF, rd, e, lat, cl);
    issue(1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
    RST_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs: valid=%b ready=%b rdata=%h err=%b required all 0",
               rsp_valid, req_ready, rsp_rdata, rsp_err);
    end
    @(negedge CLK);
    @(negedge CLK);
    RST_n = 1'b1;
    @(negedge CLK);
    ref_access(1'b0, 32'h20, 32'h0, 4'h0, er, ee);
    do_txn(1'b0, 32'h20, 32'h0, 4'h0, rd, e, lat, cl);
    checks++;
    if (rd !== 32'h12345678 || e !== 1'b0) begin
      failures++; $display("FAIL mid_reset_discard: rdata=%h err=%b required 12345678/0", rd, e);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] rd, er, exp_rd;
    logic        e, ee, cl, exp_e;
    int          lat;
    ref_access(1'b0, 32'h10, 32'h0, 4'h0, er, ee);
`ifdef MISALIGN_CHECK_EN
    exp_rd = 32'h0;
    exp_e  = 1'b1;
`else
    exp_rd = er;
    exp_e  = 1'b0;
`endif
    do_txn(1'b0, 32'h12, 32'h0, 4'h0, rd, e, lat, cl);
    checks++;
    if (rd !== exp_rd || e !== exp_e || lat != int'(WaitCycles) + 1) begin
      failures++;
      $display("FAIL misalign_0x12: rdata=%h err=%b lat=%0d required %h/%b/%0d", rd, e, lat,
               exp_rd, exp_e, WaitCycles + 1);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, er, addr, wdata;
    logic        e, ee, cl, we;
    logic [3:0]  be;
    int          lat, r;
    for (int w = 0; w < int'(Words); w++) begin
      wdata = $urandom;
      ref_access(1'b1, 32'(w * 4), wdata, 4'hF, er, ee);
      do_txn(1'b1, 32'(w * 4), wdata, 4'hF, rd, e, lat, cl);
    end
    for (int n = 0; n < 200; n++) begin
      r     = int'($urandom_range(0, 9));
      we    = 1'($urandom);
      wdata = $urandom;
      be    = 4'($urandom);
      addr  = 32'($urandom_range(0, Words - 1) * 4);
      if (r == 0) addr = addr | (32'($urandom_range(1, 255)) << 24) | 32'h0000_0100;
      if (r == 1) addr = addr + 32'($urandom_range(1, 3));
      ref_access(we, addr, wdata, be, er, ee);
      do_txn(we, addr, wdata, be, rd, e, lat, cl);
      checks++;
      if (rd !== er || e !== ee || lat != int'(WaitCycles) + 1 || cl !== 1'b1) begin
        failures++;
        $display("FAIL random%0d: we=%b addr=%h rdata=%h err=%b lat=%0d clr=%b required %h/%b/%0d/1",
                 n, we, addr, rd, e, lat, cl, er, ee, WaitCycles + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_enable();
    test_out_of_range();
    test_backpressure();
    test_reset_mid();
    test_misalign();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
